// File: rtl/cpu_agu.sv
// cpu_agu: address-generation unit for the NES CPU core.
// Fetches operand bytes at the program counter, applies X/Y indexing with
// zero-page wrap and page-cross correction, and presents the effective
// address with a one-cycle done pulse.
// Optional build macro: AGU_IND_JMP_EN enables mode 8 (JMP indirect, with
// the original pointer page-wrap behaviour).
module cpu_agu #(
  parameter int DW = 8,
  parameter logic [DW-1:0] ZP_HI = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      mode,
  input  logic            store,
  input  logic [2*DW-1:0] pc,
  input  logic [DW-1:0]   x_reg,
  input  logic [DW-1:0]   y_reg,
  input  logic [DW-1:0]   d_in,
  output logic [2*DW-1:0] bus_addr,
  output logic            pc_inc,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] ea,
  output logic            page_cross
);

  localparam logic [3:0] M_IMM  = 4'd0;
  localparam logic [3:0] M_ZP   = 4'd1;
  localparam logic [3:0] M_ZPX  = 4'd2;
  localparam logic [3:0] M_ABS  = 4'd3;
  localparam logic [3:0] M_ABSX = 4'd4;
  localparam logic [3:0] M_ABSY = 4'd5;
  localparam logic [3:0] M_INX  = 4'd6;
  localparam logic [3:0] M_INY  = 4'd7;
  localparam logic [3:0] M_IND  = 4'd8;

  localparam logic [DW-1:0] ONE = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_OP1, S_OP2, S_IDX, S_PLO, S_PHI, S_FIX, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_mode;
  logic              r_store;
  logic [DW-1:0]     r_lo;
  logic [DW-1:0]     r_hi;
  logic [DW-1:0]     r_plo;
  logic [2*DW-1:0]   r_ea;
  logic              r_pcx;

  logic [DW-1:0]     w_idx;
  logic [DW-1:0]     w_base_lo;
  logic [DW:0]       w_sum;
  logic              w_carry;
  logic              w_fix;
  logic [DW-1:0]     w_hi_adj;
  logic [DW-1:0]     w_ptr_hi;
  logic [DW-1:0]     w_lo_inc;

  // Mode 8 only exists when the indirect-jump feature is built in.
  function automatic logic mode_legal(input logic [3:0] m);
`ifdef AGU_IND_JMP_EN
    return (m <= M_IND);
`else
    return (m <= M_INY);
`endif
  endfunction

  // Index arithmetic shared by ZPX/INX (IDX), ABSX/ABSY (OP2) and INY (PHI).
  // The base low byte is the operand byte, except for INY where it is the
  // pointer low byte fetched in PLO.
  assign w_idx     = (r_mode == M_ABSY || r_mode == M_INY) ? y_reg : x_reg;
  assign w_base_lo = (r_state == S_PHI) ? r_plo : r_lo;
  assign w_sum     = {1'b0, w_base_lo} + {1'b0, w_idx};
  assign w_carry   = w_sum[DW];
  assign w_fix     = w_carry | r_store;
  // High byte arrives on d_in in the cycle the sum is formed (OP2 or PHI).
  assign w_hi_adj  = d_in + {{(DW-1){1'b0}}, w_carry};
  // Indirect pointers live in zero page, except JMP indirect which uses
  // the full operand; its high byte is never incremented.
  assign w_ptr_hi  = (r_mode == M_IND) ? r_hi : ZP_HI;
  assign w_lo_inc  = r_lo + ONE;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and per-cycle bus outputs.
  always_comb begin
    w_next   = r_state;
    bus_addr = pc;
    pc_inc   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start && mode_legal(mode)) w_next = S_OP1;
      end
      S_OP1: begin
        pc_inc = 1'b1;
        case (r_mode)
          M_ZPX, M_INX:                 w_next = S_IDX;
          M_ABS, M_ABSX, M_ABSY, M_IND: w_next = S_OP2;
          M_INY:                        w_next = S_PLO;
          default:                      w_next = S_DONE;
        endcase
      end
      S_OP2: begin
        pc_inc = 1'b1;
        if (r_mode == M_ABSX || r_mode == M_ABSY) w_next = w_fix ? S_FIX : S_DONE;
        else if (r_mode == M_IND)                 w_next = S_PLO;
        else                                      w_next = S_DONE;
      end
      S_IDX: begin
        bus_addr = {ZP_HI, r_lo};
        w_next   = (r_mode == M_INX) ? S_PLO : S_DONE;
      end
      S_PLO: begin
        bus_addr = {w_ptr_hi, r_lo};
        w_next   = S_PHI;
      end
      S_PHI: begin
        bus_addr = {w_ptr_hi, w_lo_inc};
        if (r_mode == M_INY) w_next = w_fix ? S_FIX : S_DONE;
        else                 w_next = S_DONE;
      end
      S_FIX: begin
        bus_addr = {r_hi, r_lo};
        w_next   = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the request and produce the effective address in its final cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= M_IMM;
      r_store <= 1'b0;
      r_ea    <= '0;
      r_pcx   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && mode_legal(mode)) begin
            r_mode  <= mode;
            r_store <= store;
          end
        end
        S_OP1: begin
          if (r_mode == M_IMM) begin
            r_ea  <= pc;
            r_pcx <= 1'b0;
          end else if (r_mode == M_ZP) begin
            r_ea  <= {ZP_HI, d_in};
            r_pcx <= 1'b0;
          end
        end
        S_OP2: begin
          if (r_mode == M_ABS) begin
            r_ea  <= {d_in, r_lo};
            r_pcx <= 1'b0;
          end else if (r_mode == M_ABSX || r_mode == M_ABSY) begin
            r_ea  <= {w_hi_adj, w_sum[DW-1:0]};
            r_pcx <= w_carry;
          end
        end
        S_IDX: begin
          if (r_mode == M_ZPX) begin
            r_ea  <= {ZP_HI, w_sum[DW-1:0]};
            r_pcx <= 1'b0;
          end
        end
        S_PHI: begin
          if (r_mode == M_INY) begin
            r_ea  <= {w_hi_adj, w_sum[DW-1:0]};
            r_pcx <= w_carry;
          end else begin
            r_ea  <= {d_in, r_plo};
            r_pcx <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand and pointer byte capture; r_lo is reused for the indexed low
  // byte so FIX and PLO/PHI can drive it directly.
  always_ff @(posedge clk) begin
    case (r_state)
      S_OP1: r_lo <= d_in;
      S_OP2: begin
        r_hi <= d_in;
        if (r_mode == M_ABSX || r_mode == M_ABSY) r_lo <= w_sum[DW-1:0];
      end
      S_IDX: r_lo <= w_sum[DW-1:0];
      S_PLO: r_plo <= d_in;
      S_PHI: begin
        r_hi <= d_in;
        if (r_mode == M_INY) r_lo <= w_sum[DW-1:0];
      end
      default: ;
    endcase
  end

  assign ea         = r_ea;
  assign page_cross = r_pcx;

endmodule

// File: tb/tb_cpu_agu.sv
// tb_cpu_agu: randomized bench for cpu_agu with a behavioural address model
// and a flat 64 KiB memory. Honours AGU_IND_JMP_EN the same way as the RTL.
module tb_cpu_agu;

  localparam logic [7:0] ZP = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  mode;
  logic        store;
  logic [15:0] pc;
  logic [7:0]  x_reg;
  logic [7:0]  y_reg;
  logic [7:0]  d_in;
  logic [15:0] bus_addr;
  logic        pc_inc;
  logic        busy;
  logic        done;
  logic [15:0] ea;
  logic        page_cross;

  logic [7:0] mem [0:65535];

  assign d_in = mem[bus_addr];

  always #5 clk = ~clk;

  cpu_agu #(.DW(8), .ZP_HI(ZP)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .store(store),
    .pc(pc), .x_reg(x_reg), .y_reg(y_reg), .d_in(d_in),
    .bus_addr(bus_addr), .pc_inc(pc_inc), .busy(busy), .done(done),
    .ea(ea), .page_cross(page_cross)
  );

  // kind: 0 idle cycle, 1 busy cycle, 2 done cycle
  typedef struct {
    int          kind;
    logic [15:0] bus;
    logic        inc;
    logic [15:0] ea;
    logic        pcx;
  } exp_t;

  typedef struct {
    string       nm;
    logic [15:0] act;
    logic [15:0] exp;
  } req_t;

  exp_t exp_q[$];
  exp_t tr_q[$];
  req_t req_q[$];

  int          n_vec = 0;
  int          n_err = 0;
  int          last_len;
  logic [15:0] m_ea = '0;
  logic        m_pcx = 1'b0;

  function automatic void chk16(input string nm, input logic [15:0] a, input logic [15:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %04h, want %04h (t=%0t)", nm, a, e, $time);
    end
  endfunction

  function automatic void chk1(input string nm, input logic a, input logic e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0b, want %0b (t=%0t)", nm, a, e, $time);
    end
  endfunction

  function automatic void pin(input string nm, input logic [15:0] a, input logic [15:0] e);
    req_t r;
    r.nm = nm; r.act = a; r.exp = e;
    req_q.push_back(r);
  endfunction

  // Single checker: drains pinned literal checks, then compares this cycle.
  always @(negedge clk) begin
    exp_t e;
    req_t r;
    while (req_q.size() > 0) begin
      r = req_q.pop_front();
      chk16(r.nm, r.act, r.exp);
    end
    if (rst) begin
      m_ea  <= '0;
      m_pcx <= 1'b0;
    end else begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin
        e.kind = 0; e.bus = pc; e.inc = 1'b0; e.ea = '0; e.pcx = 1'b0;
      end
      if (e.kind == 0) begin
        chk16("idle_bus", bus_addr, pc);
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_done", done, 1'b0);
        chk1("idle_pc_inc", pc_inc, 1'b0);
        chk16("held_ea", ea, m_ea);
        chk1("held_page_cross", page_cross, m_pcx);
      end else begin
        chk16("bus_addr", bus_addr, e.bus);
        chk1("pc_inc", pc_inc, e.inc);
        chk1("busy", busy, 1'b1);
        chk1("done", done, e.kind == 2);
        if (e.kind == 2) begin
          chk16("ea", ea, e.ea);
          chk1("page_cross", page_cross, e.pcx);
          m_ea  <= e.ea;
          m_pcx <= e.pcx;
        end
      end
    end
  end

  function automatic void pb(input logic [15:0] b, input logic inc);
    exp_t t;
    t.kind = 1; t.bus = b; t.inc = inc; t.ea = '0; t.pcx = 1'b0;
    tr_q.push_back(t);
  endfunction

  function automatic void fin(input logic [15:0] e16, input logic pcx);
    exp_t t;
    int   ni = 0;
    foreach (tr_q[i]) if (tr_q[i].inc) ni++;
    t.kind = 2; t.bus = pc + 16'(ni); t.inc = 1'b0; t.ea = e16; t.pcx = pcx;
    tr_q.push_back(t);
  endfunction

  // Reference: list of bus cycles plus final address for one instruction.
  task automatic build(input logic [3:0] md, input logic st,
                       input logic [7:0] xv, input logic [7:0] yv);
    logic [7:0]  lo, hi, q, idx;
    logic [15:0] p, base, e16, pa;
    logic        pcx;
    p  = pc;
    lo = mem[p];
    hi = mem[p + 16'd1];
    tr_q.delete();
    pcx = 1'b0;
    e16 = '0;
    case (md)
      4'd0: begin pb(p, 1'b1); e16 = p; end
      4'd1: begin pb(p, 1'b1); e16 = {ZP, lo}; end
      4'd2: begin
        pb(p, 1'b1); pb({ZP, lo}, 1'b0);
        e16 = {ZP, 8'(lo + xv)};
      end
      4'd3: begin pb(p, 1'b1); pb(p + 16'd1, 1'b1); e16 = {hi, lo}; end
      4'd4, 4'd5: begin
        idx  = (md == 4'd4) ? xv : yv;
        base = {hi, lo};
        e16  = base + 16'(idx);
        pcx  = (e16[15:8] != hi);
        pb(p, 1'b1); pb(p + 16'd1, 1'b1);
        if (pcx || st) pb({hi, 8'(lo + idx)}, 1'b0);
      end
      4'd6: begin
        q = 8'(lo + xv);
        pb(p, 1'b1); pb({ZP, lo}, 1'b0); pb({ZP, q}, 1'b0); pb({ZP, 8'(q + 8'd1)}, 1'b0);
        e16 = {mem[{ZP, 8'(q + 8'd1)}], mem[{ZP, q}]};
      end
      4'd7: begin
        pb(p, 1'b1); pb({ZP, lo}, 1'b0); pb({ZP, 8'(lo + 8'd1)}, 1'b0);
        base = {mem[{ZP, 8'(lo + 8'd1)}], mem[{ZP, lo}]};
        e16  = base + 16'(yv);
        pcx  = (e16[15:8] != base[15:8]);
        if (pcx || st) pb({base[15:8], 8'(base[7:0] + yv)}, 1'b0);
      end
      default: begin
        pa = {hi, 8'(lo + 8'd1)};
        pb(p, 1'b1); pb(p + 16'd1, 1'b1); pb({hi, lo}, 1'b0); pb(pa, 1'b0);
        e16 = {mem[pa], mem[{hi, lo}]};
      end
    endcase
    fin(e16, pcx);
    last_len = tr_q.size();
  endtask

  task automatic push_idle();
    exp_t t;
    t.kind = 0; t.bus = pc; t.inc = 1'b0; t.ea = '0; t.pcx = 1'b0;
    exp_q.push_back(t);
  endtask

  // Issue one instruction from IDLE and walk it to the following IDLE.
  // With noisy set, start/mode/store are scrambled while busy.
  task automatic run_txn(input logic [3:0] md, input logic st,
                         input logic [7:0] xv, input logic [7:0] yv, input logic noisy);
    int n;
    build(md, st, xv, yv);
    n = tr_q.size();
    x_reg = xv; y_reg = yv; mode = md; store = st; start = 1'b1;
    push_idle();
    foreach (tr_q[i]) exp_q.push_back(tr_q[i]);
    for (int k = 0; k <= n; k++) begin
      @(posedge clk); #1;
      if (k > 0 && tr_q[k-1].inc) pc = pc + 16'd1;
      if (k < n && noisy) begin
        start = 1'($urandom_range(0, 1));
        mode  = 4'($urandom);
        store = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'($urandom_range(0, 1));
`ifdef AGU_IND_JMP_EN
      mode = 4'($urandom_range(9, 15));
`else
      mode = 4'($urandom_range(8, 15));
`endif
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic set_ops(input logic [15:0] p, input logic [7:0] lo, input logic [7:0] hi);
    pc = p;
    mem[p] = lo;
    mem[p + 16'd1] = hi;
  endtask

  // Watchdog: the run is bounded by construction; this only guards hangs.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] md;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst = 1'b1; start = 1'b0; mode = '0; store = 1'b0;
    pc = 16'h8000; x_reg = '0; y_reg = '0;
    @(posedge clk); #2;
    pin("rst_busy", {15'd0, busy}, 16'd0);
    pin("rst_done", {15'd0, done}, 16'd0);
    pin("rst_pc_inc", {15'd0, pc_inc}, 16'd0);
    pin("rst_ea", ea, 16'h0000);
    pin("rst_page_cross", {15'd0, page_cross}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    gap(2);

    // ABSX crossing a page without store: FIX taken.
    set_ops(16'h8000, 8'hF0, 8'h12);
    run_txn(4'd4, 1'b0, 8'h20, 8'h00, 1'b0);
    pin("t1_fix_bus", tr_q[2].bus, 16'h1210);
    pin("t1_cycles", 16'(last_len), 16'd4);
    pin("t1_ea", ea, 16'h1310);
    pin("t1_pcx", {15'd0, page_cross}, 16'd1);

    // ABSX without page cross, load then store timing.
    set_ops(16'h8010, 8'h10, 8'h12);
    run_txn(4'd4, 1'b0, 8'h20, 8'h00, 1'b0);
    pin("t2_cycles_ld", 16'(last_len), 16'd3);
    pin("t2_ea_ld", ea, 16'h1230);
    set_ops(16'h8010, 8'h10, 8'h12);
    run_txn(4'd4, 1'b1, 8'h20, 8'h00, 1'b0);
    pin("t2_cycles_st", 16'(last_len), 16'd4);
    pin("t2_ea_st", ea, 16'h1230);
    pin("t2_pcx_st", {15'd0, page_cross}, 16'd0);

    // Zero-page wrap on ZPX and on the INX pointer.
    set_ops(16'h8020, 8'hF0, 8'h00);
    run_txn(4'd2, 1'b0, 8'h20, 8'h00, 1'b0);
    pin("t3_zpx_cycles", 16'(last_len), 16'd3);
    pin("t3_zpx_ea", ea, 16'h0010);
    set_ops(16'h8030, 8'hFF, 8'h00);
    mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
    run_txn(4'd6, 1'b0, 8'h00, 8'h00, 1'b0);
    pin("t3_inx_cycles", 16'(last_len), 16'd5);
    pin("t3_inx_ea", ea, 16'h1234);

    // INY with and without page cross.
    mem[16'h0040] = 8'h80; mem[16'h0041] = 8'h03;
    set_ops(16'h8040, 8'h40, 8'h00);
    run_txn(4'd7, 1'b0, 8'h00, 8'h10, 1'b0);
    pin("t4_cycles_a", 16'(last_len), 16'd4);
    pin("t4_ea_a", ea, 16'h0390);
    pin("t4_pcx_a", {15'd0, page_cross}, 16'd0);
    set_ops(16'h8040, 8'h40, 8'h00);
    run_txn(4'd7, 1'b0, 8'h00, 8'h90, 1'b0);
    pin("t4_cycles_b", 16'(last_len), 16'd5);
    pin("t4_ea_b", ea, 16'h0410);
    pin("t4_pcx_b", {15'd0, page_cross}, 16'd1);

`ifdef AGU_IND_JMP_EN
    set_ops(16'h8050, 8'hFF, 8'h02);
    mem[16'h02FF] = 8'h34; mem[16'h0200] = 8'h12;
    run_txn(4'd8, 1'b0, 8'h00, 8'h00, 1'b0);
    pin("t6_cycles", 16'(last_len), 16'd5);
    pin("t6_ea", ea, 16'h1234);
`else
    mode = 4'd8; start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    pin("t6_mode8_busy", {15'd0, busy}, 16'd0);
`endif

    // Asynchronous reset in the PHI cycle of INX, with starts while busy.
    set_ops(16'h8100, 8'hFE, 8'h00);
    build(4'd6, 1'b0, 8'h01, 8'h00);
    x_reg = 8'h01; mode = 4'd6; store = 1'b0; start = 1'b1;
    push_idle();
    for (int i = 0; i < 3; i++) exp_q.push_back(tr_q[i]);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k > 0 && tr_q[k-1].inc) pc = pc + 16'd1;
      mode = 4'd1; start = 1'b1;
    end
    #2 rst = 1'b1;
    #1;
    pin("t5_busy", {15'd0, busy}, 16'd0);
    pin("t5_done", {15'd0, done}, 16'd0);
    pin("t5_pc_inc", {15'd0, pc_inc}, 16'd0);
    pin("t5_ea", ea, 16'h0000);
    pin("t5_pcx", {15'd0, page_cross}, 16'd0);
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    gap(3);
    set_ops(16'h8200, 8'h55, 8'h00);
    run_txn(4'd1, 1'b0, 8'h00, 8'h00, 1'b0);
    pin("t5_zp_cycles", 16'(last_len), 16'd2);
    pin("t5_zp_ea", ea, 16'h0055);

    // Randomized instructions with noise on start while busy.
    for (int t = 0; t < 300; t++) begin
`ifdef AGU_IND_JMP_EN
      md = 4'($urandom_range(0, 8));
`else
      md = 4'($urandom_range(0, 7));
`endif
      pc = 16'($urandom);
      run_txn(md, 1'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) gap(int'($urandom_range(1, 3)));
    end

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
